// File: rtl/riscy_mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between the
// instruction-fetch and data ports; an in-order owner FIFO routes responses.
module riscy_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               instr_req_i,
   output logic                               instr_gnt_o,
   input  logic [ADDR_WIDTH-1:0]              instr_addr_i,
   output logic                               instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]              instr_rdata_o,
   input  logic                               data_req_i,
   output logic                               data_gnt_o,
   input  logic                               data_we_i,
   input  logic [DATA_WIDTH/8-1:0]            data_be_i,
   input  logic [ADDR_WIDTH-1:0]              data_addr_i,
   input  logic [DATA_WIDTH-1:0]              data_wdata_i,
   output logic                               data_rvalid_o,
   output logic [DATA_WIDTH-1:0]              data_rdata_o,
   output logic                               mem_req_o,
   input  logic                               mem_gnt_i,
   output logic                               mem_we_o,
   output logic [DATA_WIDTH/8-1:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0]              mem_addr_o,
   output logic [DATA_WIDTH-1:0]              mem_wdata_o,
   input  logic                               mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
   output logic                               err_o
);
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Owner encoding: 0 = instruction port, 1 = data port
   logic               r_last_grant;
   logic               r_lock;
   logic               r_lock_owner;
   logic               r_err;
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_fifo [MAX_OUTSTANDING];

   logic w_full;
   logic w_lock_hold;
   logic w_sel;
   logic w_sel_req;
   logic w_accept;
   logic w_empty;
   logic w_pop;
   logic w_head;

   assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_empty = (r_count == '0);

   // A lock only survives while its owner keeps requesting
   always_comb begin
      w_lock_hold = r_lock & (r_lock_owner ? data_req_i : instr_req_i);
      w_sel       = 1'b0;
      if (w_lock_hold)
         w_sel = r_lock_owner;
      else if (instr_req_i && data_req_i)
         w_sel = ~r_last_grant;
      else
         w_sel = data_req_i;
   end

   assign w_sel_req   = w_sel ? data_req_i : instr_req_i;
   assign mem_req_o   = w_sel_req & ~w_full & ~rst_i;
   assign mem_we_o    = w_sel & data_we_i;
   assign mem_be_o    = w_sel ? data_be_i : '1;
   assign mem_addr_o  = w_sel ? data_addr_i : instr_addr_i;
   assign mem_wdata_o = w_sel ? data_wdata_i : '0;

   assign w_accept    = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = w_accept & ~w_sel;
   assign data_gnt_o  = w_accept & w_sel;

   assign w_head         = r_fifo[r_rptr];
   assign w_pop          = mem_rvalid_i & ~w_empty & ~rst_i;
   assign instr_rvalid_o = w_pop & ~w_head;
   assign data_rvalid_o  = w_pop & w_head;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

   assign outstanding_o = r_count;
   assign err_o         = r_err;

   // Arbitration, lock and occupancy state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_grant <= 1'b1;
         r_lock       <= 1'b0;
         r_lock_owner <= 1'b0;
         r_err        <= 1'b0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
      end else begin
         r_lock       <= mem_req_o & ~mem_gnt_i;
         r_lock_owner <= w_sel;
         if (w_accept) begin
            r_last_grant <= w_sel;
            r_wptr       <= r_wptr + PTR_W'(1);
         end
         if (w_pop)
            r_rptr <= r_rptr + PTR_W'(1);
         if (mem_rvalid_i && w_empty)
            r_err <= 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Owner storage needs no reset: pointers define validity
   always_ff @(posedge clk_i) begin
      if (w_accept)
         r_fifo[r_wptr] <= w_sel;
   end
endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// Randomized + directed bench for riscy_mem_arbiter against a transaction-level model.
module tb_riscy_mem_arbiter;
   localparam int unsigned MAXO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        instr_req_i = 1'b0;
   logic        instr_gnt_o;
   logic [31:0] instr_addr_i = '0;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i = 1'b0;
   logic        data_gnt_o;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = '0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic [2:0]  outstanding_o;
   logic        err_o;

   riscy_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Memory side: data values the memory still owes, in acceptance order
   logic [31:0] mem_q[$];
   // Reference model: in-flight owners (0 instr, 1 data) and their expected data
   bit          m_own[$];
   logic [31:0] m_dat[$];
   bit          m_err;
   bit          m_last;   // last granted port
   int          m_held;   // port holding the memory port after a refused request, -1 none

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return a ^ 32'hC0DE_5A5A;
   endfunction

   task automatic model_clear();
      m_own.delete(); m_dat.delete();
      m_err = 1'b0; m_last = 1'b1; m_held = -1;
   endtask

   task automatic step(input bit ireq, input logic [31:0] iaddr,
                       input bit dreq, input bit dwe, input logic [3:0] dbe,
                       input logic [31:0] daddr, input logic [31:0] dwd,
                       input bit gnt, input bit rsp);
      bit          full, sel, sreq, exp_req, exp_acc, pop, stale;
      logic [31:0] sa, sd;
      logic [3:0]  sbe;
      @(negedge clk_i);
      instr_req_i = ireq; instr_addr_i = iaddr;
      data_req_i = dreq; data_we_i = dwe; data_be_i = dbe; data_addr_i = daddr; data_wdata_i = dwd;
      mem_gnt_i = gnt;
      mem_rvalid_i = rsp;
      mem_rdata_i = (mem_q.size() != 0) ? mem_q[0] : $urandom;
      #1;
      full = (m_own.size() == MAXO);
      if (m_held >= 0 && (m_held == 1 ? dreq : ireq)) sel = (m_held == 1);
      else if (ireq && dreq)                          sel = ~m_last;
      else                                            sel = dreq;
      sreq    = sel ? dreq : ireq;
      exp_req = sreq && !full;
      exp_acc = exp_req && gnt;
      pop     = rsp && (m_own.size() != 0);
      stale   = rsp && (m_own.size() == 0);
      sa  = sel ? daddr : iaddr;
      sbe = sel ? dbe : 4'hF;
      sd  = sel ? dwd : 32'h0;
      chk("mem_req", mem_req_o, exp_req);
      chk("instr_gnt", instr_gnt_o, exp_acc && !sel);
      chk("data_gnt", data_gnt_o, exp_acc && sel);
      if (exp_req) begin
         chk("mem_addr", mem_addr_o, sa);
         chk("mem_we", mem_we_o, sel && dwe);
         chk("mem_be", mem_be_o, sbe);
         chk("mem_wdata", mem_wdata_o, sd);
      end
      chk("instr_rvalid", instr_rvalid_o, pop && !m_own[0]);
      chk("data_rvalid", data_rvalid_o, pop && m_own[0]);
      if (pop) chk(m_own[0] ? "data_rdata" : "instr_rdata",
                   m_own[0] ? data_rdata_o : instr_rdata_o, m_dat[0]);
      chk("outstanding", outstanding_o, m_own.size());
      chk("err", err_o, m_err);
      // Advance memory and model to the state after the coming edge
      if (rsp && mem_q.size() != 0) void'(mem_q.pop_front());
      if (mem_req_o && mem_gnt_i) mem_q.push_back(mem_val(mem_addr_o));
      if (pop) begin void'(m_own.pop_front()); void'(m_dat.pop_front()); end
      if (stale) m_err = 1'b1;
      if (exp_acc) begin
         m_own.push_back(sel); m_dat.push_back(mem_val(sa));
         m_last = sel; m_held = -1;
      end else if (exp_req) m_held = sel ? 1 : 0;
      else m_held = -1;
   endtask

   task automatic do_reset(input bit keep_stale);
      @(negedge clk_i);
      rst_i = 1'b1; instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
      chk("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      model_clear();
      if (!keep_stale) mem_q.delete();
   endtask

   initial begin
      model_clear();
      do_reset(1'b0);
      // Instruction-only fetches, memory answers the cycle after grant
      step(1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0);
      step(1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 1);
      step(0, 32'h0,   0, 0, 4'h0, 0, 0, 1, 1);
      step(0, 32'h0,   0, 0, 4'h0, 0, 0, 1, 0);
      // Both request every cycle: alternating grants, responses in order
      for (int i = 0; i < 6; i++)
         step(1, 32'h200 + 32'(4*i), 1, 0, 4'hF, 32'h3000 + 32'(4*i), 0, 1, i >= 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      // Instr granted, then data write stalled for 3 cycles while instr also asks
      step(1, 32'h400, 0, 0, 4'h0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h404, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 0, 0);
      step(1, 32'h404, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 1, 1);
      step(1, 32'h404, 0, 0, 4'h0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      // Fill to MAX_OUTSTANDING, then one response frees a slot a cycle later
      for (int i = 0; i < 5; i++) step(1, 32'h500 + 32'(4*i), 0, 0, 4'h0, 0, 0, 1, 0);
      step(1, 32'h510, 0, 0, 4'h0, 0, 0, 1, 1);
      step(1, 32'h510, 0, 0, 4'h0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      // Response with nothing outstanding is an error and it sticks
      step(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 32'h600, 0, 0, 4'h0, 0, 0, 1, i == 2);
      do_reset(1'b0);
      // Random traffic; responses only when the memory owes one
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom,
              $urandom_range(0, 3) != 0, (mem_q.size() != 0) && ($urandom_range(0, 2) != 0));
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 4'h0, 0, 0, 0, mem_q.size() != 0);
      // Reset with two in flight; the stale answers then flag an error
      step(1, 32'h700, 0, 0, 4'h0, 0, 0, 1, 0);
      step(1, 32'h704, 0, 0, 4'h0, 0, 0, 1, 0);
      do_reset(1'b1);
      step(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/riscy_mem_arbiter.md
Name: riscy_mem_arbiter

Overview:
Shares one req/gnt/rvalid memory port between the RISCY core's instruction-fetch and data ports. When both ports request in the same cycle, a round-robin arbiter picks one. An in-order owner FIFO tracks in-flight transactions and routes each memory response back to the port that issued it. The block sits between the core and the single-port memory model and responder in the testbench and FPGA harness.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; power of 2, at least 2

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
instr_req_i  in  1  instruction fetch request
instr_gnt_o  out  1  instruction request accepted this cycle
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_rvalid_o  out  1  instruction response valid (1-cycle pulse)
instr_rdata_o  out  DATA_WIDTH  fetched instruction
data_req_i  in  1  data request
data_gnt_o  out  1  data request accepted this cycle
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  DATA_WIDTH/8  byte enables
data_addr_i  in  ADDR_WIDTH  data address
data_wdata_i  in  DATA_WIDTH  write data
data_rvalid_o  out  1  data response valid (1-cycle pulse; also issued for writes)
data_rdata_o  out  DATA_WIDTH  read data
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepts request
mem_we_o  out  1  write enable to memory
mem_be_o  out  DATA_WIDTH/8  byte enables to memory
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory read data
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current in-flight count
err_o  out  1  sticky: a response arrived with no transaction outstanding

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO is emptied and outstanding_o = 0.
  - err_o = 0, lock is cleared, and last_grant is set to "data", so instr wins the first conflict.
  - In-flight transactions are forgotten.
  - mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o are 0 during reset.
- full = (outstanding_o == MAX_OUTSTANDING), taken from the registered count.
  - When full: mem_req_o = 0 and both grants = 0.
  - A pop in the same cycle does not unblock the request; acceptance resumes the next cycle.
- Selection, combinational:
  - If locked, select the locked owner.
  - Otherwise, if only one port requests, select it.
  - If both request, select the port that is not last_grant.
- Request path, combinational:
  - mem_req_o = selected req & !full & !rst_i.
  - mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are muxed from the selected port.
  - For an instruction request: we = 0, be = all ones, wdata = 0.
- Grant, combinational: the selected port's gnt_o = mem_req_o & mem_gnt_i. The other port's gnt_o = 0. Zero-cycle grant latency.
- Accept = mem_req_o & mem_gnt_i. On accept:
  - Push the owner ID (0 = instr, 1 = data) into the FIFO.
  - last_grant <= owner.
  - Clear the lock.
- Lock: if mem_req_o & !mem_gnt_i, then lock <= 1 and the owner is held. This keeps the address stable until grant. If the locked port drops its req (protocol violation), the lock clears and normal arbitration resumes the same cycle.
- Response path:
  - On mem_rvalid_i with the FIFO not empty: pop the head and pulse the owner's rvalid_o in the same cycle (combinational, zero added latency).
  - instr_rdata_o and data_rdata_o both always carry mem_rdata_i.
  - On mem_rvalid_i with the FIFO empty: no rvalid is forwarded and err_o <= 1. err_o holds until reset. This includes stale responses after a mid-operation reset.
- Push and pop in the same cycle: the count is unchanged, and FIFO pointers wrap modulo MAX_OUTSTANDING.
- Responses are strictly in order. The memory never answers a transaction in the cycle it is accepted.

Test Plan:
- Instr only, 0x100 then 0x104; memory grants immediately and returns 0x00000013 one cycle later -> instr_gnt_o pulses in the request cycles, instr_rvalid_o pulses with rdata 0x13, data_rvalid_o stays 0.
- Both request every cycle, mem_gnt_i = 1 -> grants alternate instr, data, instr, data starting with instr after reset; the response order matches the grant order.
- Data write to 0x2000, be = 0011, mem_gnt_i low for 3 cycles while instr also requests -> the data request stays selected with address and data stable, instr gets no grant until the data grant, then data_rvalid_o arrives for the write.
- Hold mem_rvalid_i low while issuing 5 instr requests with MAX_OUTSTANDING = 4 -> 4 grants, outstanding_o = 4, mem_req_o = 0 for the 5th; after one response, the 5th is granted on the next cycle.
- mem_rvalid_i pulse with nothing outstanding -> err_o = 1 and stays 1; no rvalid is forwarded.
- Reset asserted with 2 transactions in flight -> outstanding_o = 0 the next cycle; a subsequent stale mem_rvalid_i sets err_o.
